// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture block.
// State encoding, default sizes and the table-width helper.
package tt_pkg;

  localparam int N_IN_DEF = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT,
    ST_FIN
  } state_t;

  function automatic int tw_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_minterm_emitter.sv
// Walks the captured table and streams ON-set indices in ascending
// order over valid/ready; strobes o_done once the last index is handled.
module tt_minterm_emitter
  import tt_pkg::*;
#(
  parameter  int N_IN = N_IN_DEF,
  localparam int TW   = tw_of(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TW-1:0]   i_table,
  input  logic            i_go,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [N_IN-1:0] o_index,
  output logic            o_done
);

  logic            r_active;
  logic            r_valid;
  logic [N_IN-1:0] r_idx;

  logic            w_adv;
  logic            w_last;
  logic [N_IN-1:0] w_nidx;

  // A pending index only moves on after a handshake.
  assign w_adv  = r_active && (!r_valid || i_ready);
  assign w_last = &r_idx;
  assign w_nidx = r_idx + 1'b1;

  assign o_valid = r_valid;
  assign o_index = r_idx;
  assign o_done  = w_adv && w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_idx    <= '0;
      r_valid  <= i_table[0];
    end else if (w_adv) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_valid  <= 1'b0;
      end else begin
        r_idx   <= w_nidx;
        r_valid <= i_table[w_nidx];
      end
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all input combinations into an external function, records its
// truth table and ON-set size, then streams the ON-set minterm indices.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEF,
  parameter  int SETTLE = 1,
  localparam int TW     = tw_of(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            f_in,
  output logic            busy,
  output logic [TW-1:0]   table_out,
  output logic [N_IN:0]   minterm_count,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_index,
  output logic            done
);

  // SETTLE cycles are spent in ST_SETTLE; with SETTLE=0 it is skipped.
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_t AFTER_STIM =
    (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t           r_state;
  state_t           w_state_n;
  logic [N_IN-1:0]  r_stim;
  logic [TW-1:0]    r_table;
  logic [N_IN:0]    r_count;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last_stim;
  logic             w_go;
  logic             w_emit_done;

  assign w_last_stim = &r_stim;
  assign w_go = (r_state == ST_SAMPLE) && w_last_stim;

  assign stim          = r_stim;
  assign busy          = r_busy;
  assign table_out     = r_table;
  assign minterm_count = r_count;
  assign done          = r_done;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_n = AFTER_STIM;
      ST_SETTLE: if (r_cnt == SET_LAST) w_state_n = ST_SAMPLE;
      ST_SAMPLE: w_state_n = w_last_stim ? ST_EMIT : AFTER_STIM;
      ST_EMIT:   if (w_emit_done) w_state_n = ST_FIN;
      ST_FIN:    w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_stim  <= '0;
      r_table <= '0;
      r_count <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != ST_IDLE);
      r_done  <= (w_state_n == ST_FIN);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_stim  <= '0;
            r_table <= '0;
            r_count <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt + 1'b1;
        ST_SAMPLE: begin
          r_table[r_stim] <= f_in;
          r_count <= r_count + {{N_IN{1'b0}}, f_in};
          if (!w_last_stim) begin
            r_stim <= r_stim + 1'b1;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  tt_minterm_emitter #(
    .N_IN(N_IN)
  ) u_emit (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_table (r_table),
    .i_go    (w_go),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_index (m_index),
    .o_done  (w_emit_done)
  );

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench: three instances (SETTLE 1, 0, 3) share stimulus;
// a negedge monitor checks the stream of the selected instance.
module tb_truth_table_capture;

  localparam int TW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        m_ready;
  int          sel;
  int          rmode;
  logic [31:0] ftab;

  logic        start_a, start_b, start_c;
  logic [4:0]  stim_a, stim_b, stim_c;
  logic        f_a, f_b, f_c;
  logic        busy_a, busy_b, busy_c;
  logic [31:0] tbl_a, tbl_b, tbl_c;
  logic [5:0]  cnt_a, cnt_b, cnt_c;
  logic        mv_a, mv_b, mv_c;
  logic [4:0]  mi_a, mi_b, mi_c;
  logic        dn_a, dn_b, dn_c;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  // Function under test with a propagation delay of SETTLE cycles.
  logic [4:0] da1, dc1, dc2, dc3;
  always @(posedge clk) begin
    da1 <= stim_a;
    dc1 <= stim_c;
    dc2 <= dc1;
    dc3 <= dc2;
  end
  assign f_a = ftab[da1];
  assign f_b = ftab[stim_b];
  assign f_c = ftab[dc3];

  truth_table_capture #(.N_IN(5), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a),
    .f_in(f_a), .busy(busy_a), .table_out(tbl_a),
    .minterm_count(cnt_a), .m_valid(mv_a), .m_ready(m_ready),
    .m_index(mi_a), .done(dn_a));

  truth_table_capture #(.N_IN(5), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b),
    .f_in(f_b), .busy(busy_b), .table_out(tbl_b),
    .minterm_count(cnt_b), .m_valid(mv_b), .m_ready(m_ready),
    .m_index(mi_b), .done(dn_b));

  truth_table_capture #(.N_IN(5), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stim(stim_c),
    .f_in(f_c), .busy(busy_c), .table_out(tbl_c),
    .minterm_count(cnt_c), .m_valid(mv_c), .m_ready(m_ready),
    .m_index(mi_c), .done(dn_c));

  logic        mv, md, bsy;
  logic [4:0]  mi, tstim;
  logic [31:0] ttbl;
  logic [5:0]  tcnt;

  always_comb begin
    mv = mv_a; mi = mi_a; md = dn_a; bsy = busy_a;
    tstim = stim_a; ttbl = tbl_a; tcnt = cnt_a;
    case (sel)
      1: begin
        mv = mv_b; mi = mi_b; md = dn_b; bsy = busy_b;
        tstim = stim_b; ttbl = tbl_b; tcnt = cnt_b;
      end
      2: begin
        mv = mv_c; mi = mi_c; md = dn_c; bsy = busy_c;
        tstim = stim_c; ttbl = tbl_c; tcnt = cnt_c;
      end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int q[$];
  logic [31:0] exp_tbl;
  int exp_cnt;
  int exp_lat;
  int s_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int s);
    return (s == 1) ? 0 : (s == 2) ? 3 : 1;
  endfunction

  // Behavioural model: ON-set of f in ascending order and its size.
  task automatic load_model(input logic [31:0] f, input logic [31:0] etbl);
    q.delete();
    exp_cnt = 0;
    for (int k = 0; k < TW; k++)
      if (f[k]) begin
        q.push_back(k);
        exp_cnt++;
      end
    exp_tbl = etbl;
  endtask

  // Ready driver: 0 always ready, 1 random, 2 stall 5 cycles per index.
  int stall = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (mv && stall < 5) begin
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = mv;
            stall = 0;
          end
        end
      endcase
    end
  end

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [4:0] prev_i = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(mv), 64'd1);
        chk("hold_index", 64'(mi), 64'(prev_i));
      end
      if (mv && m_ready) begin
        if (q.size() == 0) chk("extra_index", 64'(mi), 64'hFFFF);
        else chk("m_index", 64'(mi), 64'(q.pop_front()));
      end
      if (md) begin
        done_cnt++;
        chk("left_in_queue", 64'(q.size()), 64'd0);
        chk("table_out", 64'(ttbl), 64'(exp_tbl));
        chk("minterm_count", 64'(tcnt), 64'(exp_cnt));
        chk("stim_hold", 64'(tstim), 64'd31);
        if (exp_lat >= 0)
          chk("done_latency", 64'(cyc - s_cyc), 64'(exp_lat));
      end
      prev_v = mv;
      prev_r = m_ready;
      prev_i = mi;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_start(input int s, input int rm, input logic [31:0] f,
                           input logic [31:0] etbl, input bit lat);
    sel = s;
    rmode = rm;
    ftab = f;
    load_model(f, etbl);
    exp_lat = lat ? TW * (settle_of(s) + 1) + TW : -1;
    pulse_start();
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("busy_after", 64'(bsy), 64'd0);
  endtask

  task automatic run(input int s, input int rm, input logic [31:0] f,
                     input logic [31:0] etbl, input bit lat);
    int d0;
    d0 = done_cnt;
    run_start(s, rm, f, etbl, lat);
    wait_done(d0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, 64'(tstim), 64'd0);
    chk({tag, "_busy"}, 64'(bsy), 64'd0);
    chk({tag, "_table"}, 64'(ttbl), 64'd0);
    chk({tag, "_count"}, 64'(tcnt), 64'd0);
    chk({tag, "_valid"}, 64'(mv), 64'd0);
    chk({tag, "_index"}, 64'(mi), 64'd0);
    chk({tag, "_done"}, 64'(md), 64'd0);
  endtask

  int ref_m[22] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 15,
                    19, 22, 23, 24, 25, 26, 27, 30, 31};
  logic [31:0] f_ref, f_par, f_rnd;
  logic [4:0]  kk;
  int          d0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel = 0;
    rmode = 0;
    ftab = '0;
    exp_lat = -1;
    f_ref = '0;
    foreach (ref_m[i]) f_ref[ref_m[i]] = 1'b1;
    for (int k = 0; k < TW; k++) begin
      kk = k[4:0];
      f_par[k] = ^kk;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 0, f_ref, 32'hCFC89F7F, 1'b1);
    run(0, 0, 32'h0, 32'h0, 1'b1);
    run(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run(0, 2, f_ref, 32'hCFC89F7F, 1'b0);
    run(1, 0, f_par, 32'h96696996, 1'b1);
    run(2, 0, f_par, 32'h96696996, 1'b1);
    run(2, 1, f_ref, 32'hCFC89F7F, 1'b0);

    // Start pulses mid-capture must be ignored.
    f_rnd = $urandom();
    d0 = done_cnt;
    run_start(0, 1, f_rnd, f_rnd, 1'b0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0);

    for (int r = 0; r < 6; r++) begin
      f_rnd = $urandom();
      run(0, int'($urandom_range(0, 2)), f_rnd, f_rnd, 1'b0);
    end

    // Reset mid-capture, then a fresh run.
    f_rnd = $urandom() | 32'h1;
    run_start(0, 0, f_rnd, f_rnd, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    q.delete();
    run(0, 0, f_rnd, f_rnd, 1'b1);

    // Reset while the stream is stalled.
    d0 = done_cnt;
    run_start(0, 2, f_ref, 32'hCFC89F7F, 1'b0);
    for (int i = 0; i < 200 && !mv; i++) @(posedge clk);
    chk("stall_seen_valid", 64'(mv), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_rst_valid", 64'(mv), 64'd0);
    chk("stall_rst_busy", 64'(bsy), 64'd0);
    rst_n = 1'b1;
    q.delete();
    repeat (40) @(posedge clk);
    #1;
    chk("stall_rst_no_done", 64'(done_cnt - d0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential characteriser for 5-input combinational Boolean functions; the inverse of a minterm-equation block.
- Sweeps every input combination into an external function under test, samples its 1-bit output, and assembles the 32-bit truth table and minterm count.
- Streams the ON-set minterm indices in ascending order over a valid/ready interface.
- Sits in the Boolean-simplification lab bench between any combinational function module and the checker/logger.

Parameters:
- N_IN, 5, number of function inputs; truth-table width TW = 2**N_IN.
- SETTLE, 1, cycles to wait after stim changes before f_in is sampled; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin capture; honoured only in IDLE.
- stim  out  N_IN  drive vector to function under test; MSB = input a, LSB = input e.
- f_in  in  1  function output for current stim.
- busy  out  1  high in every state except IDLE.
- table_out  out  TW  captured truth table; bit k = f(stim=k).
- minterm_count  out  N_IN+1  number of 1 bits in table_out.
- m_valid  out  1  minterm index available.
- m_ready  in  1  consumer accepts index.
- m_index  out  N_IN  current minterm index.
- done  out  1  one-cycle pulse when the minterm stream completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; stim=0, busy=0, table_out=0, minterm_count=0, m_valid=0, m_index=0, done=0; settle counter=0. Takes effect from any state, mid-capture or mid-stream; partial results are discarded.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, EMIT, FIN.
- IDLE:
  - start=1 -> SETTLE; stim<=0, table_out<=0, minterm_count<=0, settle counter<=0.
  - start=0 -> remain; table_out and minterm_count hold their last values.
- SETTLE: counter increments each cycle; when counter==SETTLE -> SAMPLE. With SETTLE=0, go directly to SAMPLE on the next cycle.
- SAMPLE (one cycle):
  - table_out[stim]<=f_in; minterm_count += f_in.
  - If stim==TW-1 -> EMIT with scan index 0.
  - Else stim<=stim+1, counter<=0 -> SETTLE.
- Capture timing: each combination occupies SETTLE+1 cycles, so capture spans TW*(SETTLE+1) cycles (64 at defaults). f_in is sampled exactly SETTLE+1 cycles after stim last changed.
- stim holds TW-1 after capture; no wrap to 0 until the next start.
- EMIT: scan index i walks 0..TW-1.
  - If table_out[i]==0: advance i, one cycle per index, m_valid=0.
  - If table_out[i]==1: m_valid=1, m_index=i, held stable until m_ready=1 at a clock edge; then advance.
  - m_valid may not drop without a handshake.
  - m_ready is ignored when m_valid=0.
  - After index TW-1 is handled -> FIN.
  - Empty ON-set: m_valid never asserts and FIN is reached after TW cycles.
- FIN: done=1 for exactly one cycle, busy=0 next cycle; -> IDLE.
- start while busy=1 is ignored; no queueing.
- start held high through FIN re-triggers capture on the first IDLE cycle.
- minterm_count width N_IN+1 holds TW without overflow.

Decomposition:
- Shared package tt_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, EMIT, FIN)
  - default N_IN
  - TW derivation constant
  - SETTLE counter width (4 bits)
- One sub-module is natural: tt_minterm_emitter. It owns the EMIT scan index and the valid/ready handshake; inputs are table_out and a go strobe; it returns an emit_done strobe.

Test Plan:
- Reset, then start with f_in driven by the team's 22-minterm reference function (a MSB). Required: table_out=32'hCFC89F7F and minterm_count=22 after 64 cycles. m_index sequence is 0,1,2,3,4,5,6,8,9,10,11,12,15,19,22,23,24,25,26,27,30,31, followed by a single done pulse.
- Constant f_in=0 -> table_out=0, minterm_count=0, m_valid never high, done 64+32 cycles after start. f_in=1 -> table_out=32'hFFFFFFFF, count=32, indices 0..31.
- Backpressure: hold m_ready=0 for 5 cycles at each valid. m_index and m_valid stay stable; no index is dropped or duplicated; order is unchanged.
- SETTLE=0 and SETTLE=3, with f_in = parity of stim -> table_out=32'h96696996 and count=16. Capture lengths are 32 and 128 cycles respectively.
- start pulsed mid-capture -> ignored; the result is identical to an undisturbed run.
- rst_n low mid-capture -> all outputs at reset values next cycle, including table_out=0; a fresh start then completes normally.
- rst_n low during a stalled EMIT -> m_valid=0 next cycle; no done pulse.
